// File: rtl/loop_pkg.sv
// Shared field layout, beat geometry and FSM encoding for the loopback read-command responder.
package loop_pkg;

  localparam int CMD_W        = 288;
  localparam int BEAT_W       = 540;
  localparam int DATA_W       = 512;

  localparam int CMD_ADDR_LSB = 0;
  localparam int ADDR_W       = 64;
  localparam int CMD_LEN_LSB  = 64;
  localparam int LEN_W        = 16;
  localparam int CMD_TAG_LSB  = 80;
  localparam int TAG_W        = 16;

  localparam int BEAT_SOP     = 512;
  localparam int BEAT_EOP     = 513;
  localparam int BEAT_MOD_LSB = 514;
  localparam int MOD_W        = 6;
  localparam int BEAT_TAG_LSB = 520;
  localparam int BEAT_PAD_LSB = 536;
  localparam int PAD_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/loop_pat_gen.sv
// Incrementing-byte pattern for one 64-byte beat; combinational, no backpressure.
// Bytes at or beyond a nonzero mod are forced to zero (mod 0 means the full beat is valid).
module loop_pat_gen
  import loop_pkg::*;
(
  input  logic [7:0]        base,
  input  logic [15:0]       beat_idx,
  input  logic [5:0]        mod,
  output logic [DATA_W-1:0] data
);

  logic [7:0] beat_base;
  logic       unused;

  // Only the low two beat-index bits survive the mod-256 byte arithmetic.
  assign unused = ^beat_idx[15:2];

  always_comb begin
    beat_base = base + {beat_idx[1:0], 6'd0};
    data      = '0;
    for (int j = 0; j < 64; j++) begin
      if (mod == 6'd0 || j < int'(mod)) begin
        data[8*j +: 8] = beat_base + 8'(j);
      end
    end
  end

endmodule

// File: rtl/loop_rcmd_rsp.sv
// Turns read commands into incrementing-pattern packets; first beat 3 cycles after the pop, beats registered.
// Almost-full stalls the packet in place; bad lengths are dropped and counted.
module loop_rcmd_rsp
  import loop_pkg::*;
#(
  parameter logic [15:0] MAX_LEN = 16'd9600,
  parameter int          CNT_WTH = 32
) (
  input  logic               clk_sys,
  input  logic               rst,
  output logic               ppm2stxm_rxffc_rd,
  input  logic [CMD_W-1:0]   ppm2stxm_rxffc_rdata,
  input  logic               ppm2stxm_rxffc_emp,
  output logic               stxm2ppm_txffd_wr,
  output logic [BEAT_W-1:0]  stxm2ppm_txffd_wdata,
  input  logic               stxm2ppm_txffd_ff,
  output logic [CNT_WTH-1:0] reg_rcmd_cnt,
  output logic [CNT_WTH-1:0] reg_pkt_cnt,
  output logic [CNT_WTH-1:0] reg_err_cnt,
  output logic [3:0]         reg_rsp_sta,
  input  logic               cnt_reg_clr
);

  logic [1:0]        rst_pipe;
  logic              rst_n;
  state_t            state, state_nxt;
  logic [7:0]        cmd_base;
  logic [15:0]       cmd_len, cmd_tag, beat_idx, last_idx;
  logic [16:0]       len_rnd;
  logic              len_bad, last, send_beat, sticky;
  logic [5:0]        mod_cur;
  logic [DATA_W-1:0] pat_data;
  logic [BEAT_W-1:0] beat;
  logic              unused;

  assign unused = ^{ppm2stxm_rxffc_rdata[CMD_W-1:CMD_TAG_LSB+TAG_W],
                    ppm2stxm_rxffc_rdata[ADDR_W-1:8]};

  // Assert asynchronously, release two clk_sys edges after rst rises.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) rst_pipe <= 2'b00;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign len_bad = (cmd_len == 16'd0) || (cmd_len > MAX_LEN);
  assign len_rnd = {1'b0, cmd_len} + 17'd63;
  assign last    = (beat_idx == last_idx);
  assign mod_cur = last ? cmd_len[5:0] : 6'd0;

  assign ppm2stxm_rxffc_rd = rst_n && (state == ST_IDLE) && !ppm2stxm_rxffc_emp;

  always_comb begin
    state_nxt = state;
    send_beat = 1'b0;
    case (state)
      ST_IDLE: if (ppm2stxm_rxffc_rd) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = len_bad ? ST_DROP : ST_SEND;
      ST_SEND: begin
        if (!stxm2ppm_txffd_ff) begin
          send_beat = 1'b1;
          if (last) state_nxt = ST_IDLE;
        end
      end
      ST_DROP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  loop_pat_gen u_pat_gen (
    .base     (cmd_base),
    .beat_idx (beat_idx),
    .mod      (mod_cur),
    .data     (pat_data)
  );

  always_comb begin
    beat                              = '0;
    beat[DATA_W-1:0]                  = pat_data;
    beat[BEAT_SOP]                    = (beat_idx == 16'd0);
    beat[BEAT_EOP]                    = last;
    beat[BEAT_MOD_LSB +: MOD_W]       = mod_cur;
    beat[BEAT_TAG_LSB +: TAG_W]       = cmd_tag;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      cmd_base             <= '0;
      cmd_len              <= '0;
      cmd_tag              <= '0;
      beat_idx             <= '0;
      last_idx             <= '0;
      stxm2ppm_txffd_wr    <= 1'b0;
      stxm2ppm_txffd_wdata <= '0;
    end else begin
      state             <= state_nxt;
      stxm2ppm_txffd_wr <= send_beat;
      if (ppm2stxm_rxffc_rd) begin
        cmd_base <= ppm2stxm_rxffc_rdata[CMD_ADDR_LSB +: 8];
        cmd_len  <= ppm2stxm_rxffc_rdata[CMD_LEN_LSB +: LEN_W];
        cmd_tag  <= ppm2stxm_rxffc_rdata[CMD_TAG_LSB +: TAG_W];
      end
      // last_idx = ceil(len/64) - 1; garbage for len 0, but that command is dropped.
      if (state == ST_LOAD) begin
        beat_idx <= '0;
        last_idx <= {5'd0, len_rnd[16:6]} - 16'd1;
      end else if (send_beat) begin
        beat_idx <= beat_idx + 16'd1;
      end
      if (send_beat) stxm2ppm_txffd_wdata <= beat;
    end
  end

  // Clear has priority over any same-cycle increment.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      reg_rcmd_cnt <= '0;
      reg_pkt_cnt  <= '0;
      reg_err_cnt  <= '0;
      sticky       <= 1'b0;
    end else if (cnt_reg_clr) begin
      reg_rcmd_cnt <= '0;
      reg_pkt_cnt  <= '0;
      reg_err_cnt  <= '0;
      sticky       <= 1'b0;
    end else begin
      if (state == ST_LOAD && !len_bad) reg_rcmd_cnt <= reg_rcmd_cnt + CNT_WTH'(1);
      if (send_beat && last)            reg_pkt_cnt  <= reg_pkt_cnt + CNT_WTH'(1);
      if (state == ST_DROP) begin
        reg_err_cnt <= reg_err_cnt + CNT_WTH'(1);
        sticky      <= 1'b1;
      end
    end
  end

  assign reg_rsp_sta = {(state != ST_IDLE), sticky, state};

endmodule

// File: tb/tb_loop_rcmd_rsp.sv
// Scenario bench for loop_rcmd_rsp: FWFT command feeder, expected-beat scoreboard and per-scenario checks.
module tb_loop_rcmd_rsp;

  typedef logic [539:0] beat_t;

  logic         clk_sys = 1'b0;
  logic         rst = 1'b0;
  logic         rd;
  logic [287:0] rdata;
  logic         emp;
  logic         wr;
  logic [539:0] wdata;
  logic         ff = 1'b0;
  logic [31:0]  rcmd_cnt, pkt_cnt, err_cnt;
  logic [3:0]   rsp_sta;
  logic         clr = 1'b0;

  logic [287:0] cmd_q[$];
  beat_t        sb[$];
  beat_t        exp_beat;
  logic         rd_seen;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;

  loop_rcmd_rsp dut (
    .clk_sys              (clk_sys),
    .rst                  (rst),
    .ppm2stxm_rxffc_rd    (rd),
    .ppm2stxm_rxffc_rdata (rdata),
    .ppm2stxm_rxffc_emp   (emp),
    .stxm2ppm_txffd_wr    (wr),
    .stxm2ppm_txffd_wdata (wdata),
    .stxm2ppm_txffd_ff    (ff),
    .reg_rcmd_cnt         (rcmd_cnt),
    .reg_pkt_cnt          (pkt_cnt),
    .reg_err_cnt          (err_cnt),
    .reg_rsp_sta          (rsp_sta),
    .cnt_reg_clr          (clr)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  function automatic beat_t model_beat(input logic [7:0] a, input int len,
                                       input logic [15:0] tag, input int idx, input int nb);
    beat_t b;
    int    i;
    b = '0;
    for (int j = 0; j < 64; j++) begin
      i = idx * 64 + j;
      if (i < len) b[8*j +: 8] = 8'((int'(a) + i) % 256);
    end
    b[512]     = (idx == 0);
    b[513]     = (idx == nb - 1);
    b[519:514] = (idx == nb - 1) ? 6'(len % 64) : 6'd0;
    b[535:520] = tag;
    return b;
  endfunction

  task automatic push_cmd(input logic [63:0] addr, input int len, input logic [15:0] tag);
    int nb;
    cmd_q.push_back({192'd0, tag, 16'(len), addr});
    if (len > 0 && len <= 9600) begin
      nb = (len + 63) / 64;
      for (int k = 0; k < nb; k++) sb.push_back(model_beat(addr[7:0], len, tag, k, nb));
    end
  endtask

  // FWFT command FIFO model; pops when the DUT read strobe was high at the edge.
  initial begin
    emp = 1'b1;
    rdata = '0;
    forever begin
      @(negedge clk_sys);
      rd_seen = rd;
      @(posedge clk_sys);
      #1;
      if (rd_seen && cmd_q.size() > 0) void'(cmd_q.pop_front());
      emp   = (cmd_q.size() == 0);
      rdata = emp ? '0 : cmd_q[0];
    end
  end

  always @(negedge clk_sys) begin
    if (rd) begin
      n_cmp++;
      if (emp) begin
        n_bad++;
        $display("FAIL rd_while_empty: rd=%b emp=%b required rd=0", rd, emp);
      end
    end
    if (wr) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got beat %h, none expected", wdata);
      end else begin
        exp_beat = sb.pop_front();
        if (wdata !== exp_beat) begin
          n_bad++;
          $display("FAIL beat: got %h required %h", wdata, exp_beat);
        end
      end
    end
  end

  task automatic clear_counters();
    @(negedge clk_sys) clr = 1'b1;
    @(negedge clk_sys) clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (k < budget && !(sb.size() == 0 && cmd_q.size() == 0 && !rsp_sta[3] && !wr)) begin
      @(negedge clk_sys);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d beats and %0d cmds left, required 0", name, sb.size(), cmd_q.size());
    end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({wr, rd, rsp_sta} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: wr=%b rd=%b sta=%h required 0", wr, rd, rsp_sta);
    end
    n_cmp++;
    if (wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_wdata: got %h required 0", wdata);
    end
    n_cmp++;
    if ({rcmd_cnt, pkt_cnt, err_cnt} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: rcmd=%0d pkt=%0d err=%0d required 0", rcmd_cnt, pkt_cnt, err_cnt);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic test_single();
    int rd_cyc, wr_cyc, k;
    rd_cyc = -1;
    wr_cyc = -1;
    push_cmd(64'h10, 64, 16'h5);
    for (k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      if (rd && rd_cyc < 0) rd_cyc = cyc;
      if (wr) begin
        wr_cyc = cyc;
        break;
      end
    end
    n_cmp++;
    if (rd_cyc < 0 || wr_cyc < 0 || wr_cyc - rd_cyc < 2) begin
      n_bad++;
      $display("FAIL first_beat_latency: rd@%0d wr@%0d required gap>=2", rd_cyc, wr_cyc);
    end
    wait_done(60, "single");
    n_cmp++;
    if (pkt_cnt !== 32'd1 || rcmd_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL single_cnt: pkt=%0d rcmd=%0d required 1 1", pkt_cnt, rcmd_cnt);
    end
  endtask

  task automatic test_multi_beat();
    clear_counters();
    push_cmd(64'hABCD_00F3, 130, 16'h1234);
    wait_done(80, "multi");
    n_cmp++;
    if (rcmd_cnt !== 32'd1 || pkt_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL multi_cnt: rcmd=%0d pkt=%0d required 1 1", rcmd_cnt, pkt_cnt);
    end
  endtask

  task automatic test_drop();
    clear_counters();
    push_cmd(64'h20, 0, 16'h1);
    push_cmd(64'h30, 9601, 16'h2);
    wait_done(60, "drop");
    n_cmp++;
    if (err_cnt !== 32'd2 || rsp_sta[2] !== 1'b1 || rcmd_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL drop_cnt: err=%0d sticky=%b rcmd=%0d required 2 1 0", err_cnt, rsp_sta[2], rcmd_cnt);
    end
    clear_counters();
    n_cmp++;
    if (err_cnt !== 32'd0 || rsp_sta[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_clr: err=%0d sticky=%b required 0 0", err_cnt, rsp_sta[2]);
    end
  endtask

  task automatic test_clr_wins();
    @(negedge clk_sys) clr = 1'b1;
    push_cmd(64'h40, 0, 16'h3);
    push_cmd(64'h50, 64, 16'h4);
    wait_done(80, "clr_wins");
    n_cmp++;
    if (err_cnt !== 32'd0 || rsp_sta[2] !== 1'b0 || rcmd_cnt !== 32'd0 || pkt_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL clr_wins: err=%0d sticky=%b rcmd=%0d pkt=%0d required all 0",
               err_cnt, rsp_sta[2], rcmd_cnt, pkt_cnt);
    end
    @(negedge clk_sys) clr = 1'b0;
  endtask

  task automatic test_backpressure();
    int k;
    clear_counters();
    push_cmd(64'h80, 256, 16'h7);
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!wr && k < 50);
    n_cmp++;
    if (!wr) begin
      n_bad++;
      $display("FAIL bp_first_beat: wr=%b required 1 within 50 cycles", wr);
    end
    ff = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      n_cmp++;
      if (wr !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: wr=%b required 0", c, wr);
      end
    end
    ff = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      @(negedge clk_sys);
      n_cmp++;
      if (wr !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_beat%0d: wr=%b required 1", b, wr);
      end
    end
    wait_done(40, "bp");
    n_cmp++;
    if (rcmd_cnt !== 32'd1 || pkt_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL bp_cnt: rcmd=%0d pkt=%0d required 1 1", rcmd_cnt, pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int nbeat, k;
    nbeat = 0;
    push_cmd(64'hC0, 512, 16'h9);
    for (k = 0; k < 60 && nbeat < 3; k++) begin
      @(negedge clk_sys);
      if (wr) nbeat++;
    end
    rst = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if (nbeat != 3 || wr !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_wr: beats=%0d wr=%b required 3 0", nbeat, wr);
    end
    n_cmp++;
    if (rcmd_cnt !== 32'd0 || rsp_sta !== 4'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: rcmd=%0d sta=%h required 0 0", rcmd_cnt, rsp_sta);
    end
    repeat (3) @(negedge clk_sys);
    rst = 1'b1;
    repeat (30) @(negedge clk_sys);
    n_cmp++;
    if (rsp_sta !== 4'd0 || rcmd_cnt !== 32'd0 || pkt_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_after: sta=%h rcmd=%0d pkt=%0d required 0 0 0", rsp_sta, rcmd_cnt, pkt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int neop, eop_cyc, k;
    neop = 0;
    eop_cyc = -1;
    clear_counters();
    for (int i = 0; i < 10; i++) push_cmd(64'(i * 16 + 3), 64, 16'(16'h100 + i));
    for (k = 0; k < 400 && neop < 10; k++) begin
      @(negedge clk_sys);
      if (wr) begin
        if (wdata[512] && eop_cyc >= 0) begin
          n_cmp++;
          if (cyc - eop_cyc - 1 > 2) begin
            n_bad++;
            $display("FAIL b2b_gap: %0d idle cycles required <=2", cyc - eop_cyc - 1);
          end
        end
        if (wdata[513]) begin
          eop_cyc = cyc;
          neop++;
        end
      end
    end
    wait_done(40, "b2b");
    n_cmp++;
    if (neop != 10 || rcmd_cnt !== 32'd10 || pkt_cnt !== 32'd10) begin
      n_bad++;
      $display("FAIL b2b_cnt: eops=%0d rcmd=%0d pkt=%0d required 10 10 10", neop, rcmd_cnt, pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_beat();
    test_drop();
    test_clr_wins();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
